// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (count, N big-endian words,
// XOR checksum) and writes the assembled words into the 256x16 instruction
// memory. The CPU sequencer is held off until the frame checksum verifies.
module imem_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic [8:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WR,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [8:0]  remaining;   // words still to receive; 256 encodes a zero count byte
  logic [7:0]  hi_byte;     // high byte of the word being assembled
  logic [7:0]  csum;        // running XOR of the count byte and all data bytes
  logic [31:0] idle_cnt;    // cycles without an accepted byte while receiving
  logic        accept;
  logic        timed_out;

  assign accept    = rx_valid && rx_ready;
  // The final idle cycle of the budget moves straight to ERR on its edge, so
  // the error state is entered exactly TIMEOUT cycles after the last byte.
  assign timed_out = (TIMEOUT != 0) && (idle_cnt == TIMEOUT - 1);

  // Frame-sequencing FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 16'h0000;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= 9'd0;
      remaining    <= 9'd0;
      hi_byte      <= 8'h00;
      csum         <= 8'h00;
      idle_cnt     <= 32'd0;
    end else if (rx_ready) begin
      // rx_ready is high exactly in COUNT, HI, LO and CHK.
      if (!accept) begin
        if (timed_out) begin
          state    <= S_ERR;
          load_err <= 1'b1;
          busy     <= 1'b0;
          rx_ready <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end else begin
        idle_cnt <= 32'd0;
        case (state)
          S_COUNT: begin
            remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            csum      <= csum ^ rx_data;
            state     <= S_HI;
          end
          S_HI: begin
            hi_byte <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= S_LO;
          end
          S_LO: begin
            mem_wdata <= {hi_byte, rx_data};
            mem_we    <= 1'b1;
            csum      <= csum ^ rx_data;
            rx_ready  <= 1'b0;
            state     <= S_WR;
          end
          S_CHK: begin
            busy     <= 1'b0;
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_COUNT;
            rx_ready     <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= 9'd0;
            mem_addr     <= BASE_ADDR;
            csum         <= 8'h00;
            idle_cnt     <= 32'd0;
          end
        end
        S_WR: begin
          mem_we       <= 1'b0;
          mem_addr     <= mem_addr + 8'd1;
          words_loaded <= words_loaded + 9'd1;
          remaining    <= remaining - 9'd1;
          rx_ready     <= 1'b1;
          state        <= (remaining == 9'd1) ? S_CHK : S_HI;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word lists,
// the expected memory writes and final status are derived from the frame
// format rules, and a negedge monitor checks every write as it happens.
module tb_imem_loader;

  localparam logic [7:0] BASE = 8'hF0;
  localparam int         TMO  = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [8:0]  words_loaded;

  imem_loader #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] words[$];
  logic        chk_on = 1'b0;
  wr_t         got_wr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Per-cycle monitor: each write must be the next expected one, no byte is
  // taken while a write is issued, and cpu_hold follows busy/failed status.
  always @(negedge clk) begin
    if (chk_on) begin
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'h0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          got_wr = exp_q.pop_front();
          chk("wr_addr", {24'h0, mem_addr}, {24'h0, got_wr.addr});
          chk("wr_data", {16'h0, mem_wdata}, {16'h0, got_wr.data});
          chk("ready_low_in_wr", {31'h0, rx_ready}, 32'h0);
        end
      end
      chk("cpu_hold_rule", {31'h0, cpu_hold}, {31'h0, busy | load_err});
    end
  end

  task automatic check_reset_values();
    chk("rst_rx_ready", {31'h0, rx_ready}, 0);
    chk("rst_mem_we", {31'h0, mem_we}, 0);
    chk("rst_mem_addr", {24'h0, mem_addr}, {24'h0, BASE});
    chk("rst_mem_wdata", {16'h0, mem_wdata}, 0);
    chk("rst_cpu_hold", {31'h0, cpu_hold}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_load_done", {31'h0, load_done}, 0);
    chk("rst_load_err", {31'h0, load_err}, 0);
    chk("rst_words", {23'h0, words_loaded}, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'h0, busy}, 1);
    chk("start_hold", {31'h0, cpu_hold}, 1);
    chk("start_ready", {31'h0, rx_ready}, 1);
    chk("start_done_clr", {31'h0, load_done}, 0);
    chk("start_err_clr", {31'h0, load_err}, 0);
    chk("start_words_clr", {23'h0, words_loaded}, 0);
  endtask

  // Present one byte after `gap` idle cycles and wait until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  // Send `words` as one frame; mask != 0 corrupts the checksum byte.
  task automatic run_frame(input logic [7:0] mask, input int maxgap,
                           input bit poke, output logic [7:0] csum);
    int          n;
    logic [7:0]  cnt_b;
    logic [7:0]  na;
    wr_t         e;
    n     = words.size();
    cnt_b = n[7:0];
    csum  = cnt_b;
    for (int i = 0; i < n; i++) begin
      csum   = csum ^ words[i][15:8] ^ words[i][7:0];
      e.addr = BASE + i[7:0];
      e.data = words[i];
      exp_q.push_back(e);
    end
    pulse_start();
    send_byte(cnt_b, pick_gap(maxgap));
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8], pick_gap(maxgap));
      if (poke && i == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(words[i][7:0], pick_gap(maxgap));
    end
    send_byte(csum ^ mask, pick_gap(maxgap));
    chk("frame_done", {31'h0, load_done}, {31'h0, mask == 8'h00});
    chk("frame_err", {31'h0, load_err}, {31'h0, mask != 8'h00});
    chk("frame_hold", {31'h0, cpu_hold}, {31'h0, mask != 8'h00});
    chk("frame_busy", {31'h0, busy}, 0);
    chk("frame_words", {23'h0, words_loaded}, 32'(n));
    na = BASE + n[7:0];
    chk("frame_addr", {24'h0, mem_addr}, {24'h0, na});
    chk("frame_writes_all", 32'(exp_q.size()), 0);
    $display("[TB] frame n=%0d mask=%02h csum=%02h done=%0b err=%0b",
             n, mask, csum, load_done, load_err);
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    wr_t        e;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values();
    chk_on = 1'b1;

    // Basic two-word frame, then the same frame with a corrupted checksum.
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    run_frame(8'h00, 0, 1'b0, cs);
    chk("basic_csum", {24'h0, cs}, 32'h42);
    run_frame(8'h01, 0, 1'b0, cs);
    chk("bad_csum_model", {24'h0, cs}, 32'h42);

    // A valid frame clears the error.
    random_words(3);
    run_frame(8'h00, 2, 1'b0, cs);

    // Full 256-word frame with rx_valid held high throughout.
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back({i[7:0], ~i[7:0]});
    run_frame(8'h00, 0, 1'b0, cs);
    chk("full_csum", {24'h0, cs}, 32'h00);
    chk("full_words", {23'h0, words_loaded}, 32'h100);

    // Random frames with random gaps, stray start pulses and bad checksums.
    for (int f = 0; f < 8; f++) begin
      random_words(int'($urandom_range(8, 1)));
      run_frame(($urandom_range(3, 0) == 0) ? 8'(($urandom % 255) + 1) : 8'h00,
                4, 1'b1, cs);
    end

    // Reset during the write cycle of word 1.
    e.addr = BASE;       e.data = 16'h1111; exp_q.push_back(e);
    e.addr = BASE + 8'd1; e.data = 16'h2222; exp_q.push_back(e);
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    send_byte(8'h22, 0);
    chk("mid_rst_we", {31'h0, mem_we}, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values();
    repeat (5) @(negedge clk);
    chk("mid_rst_writes", 32'(exp_q.size()), 0);
    $display("[TB] reset during write of word 1");
    random_words(4);
    run_frame(8'h00, 3, 1'b0, cs);

    // Timeout: count 01 plus one byte, then stall.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h5A, 0);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k == TMO - 1) begin
        chk("tmo_busy_before", {31'h0, busy}, 1);
        chk("tmo_err_before", {31'h0, load_err}, 0);
      end
    end
    chk("tmo_err", {31'h0, load_err}, 1);
    chk("tmo_done", {31'h0, load_done}, 0);
    chk("tmo_busy", {31'h0, busy}, 0);
    chk("tmo_hold", {31'h0, cpu_hold}, 1);
    chk("tmo_ready", {31'h0, rx_ready}, 0);
    chk("tmo_words", {23'h0, words_loaded}, 0);
    $display("[TB] timeout after %0d idle cycles", TMO);
    random_words(2);
    run_frame(8'h00, 1, 1'b0, cs);

    repeat (3) @(negedge clk);
    chk("final_no_pending", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
